// File: rtl/cook_pkg.sv
// Shared types and output encodings for the cooking-progress monitor.
package cook_pkg;

  typedef enum logic [2:0] {
    S_RAW,
    S_WARM,
    S_FLIP_WAIT,
    S_SEARED,
    S_DONE,
    S_BURNT
  } cook_state_t;

  localparam logic [1:0] STAT_RAW   = 2'b00;
  localparam logic [1:0] STAT_COOK  = 2'b01;
  localparam logic [1:0] STAT_DONE  = 2'b10;
  localparam logic [1:0] STAT_BURNT = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_OVERHEAT = 2'b01;
  localparam logic [1:0] CAUSE_BADFLIP  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; hit flags the increment that reaches MAX.
module sat_counter #(
  parameter int MAX = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       inc,
  output logic [$clog2(MAX+1)-1:0]   cnt,
  output logic                       hit
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);
  localparam logic [CW-1:0] TOP  = CW'(MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != TOP))
      cnt <= cnt + CW'(1);
  end

  // Combinational so the owner can act on the MAX-th event in the same edge.
  assign hit = inc && (cnt == LAST);

endmodule

// File: rtl/cook_monitor.sv
// Cooking-progress monitor: warm -> dwell -> flip (xNFLIP) -> done, with a
// sticky BURNT state and a latched fault cause.
module cook_monitor
  import cook_pkg::*;
#(
  parameter int TEMP_W       = 8,
  parameter int T_WARM       = 120,
  parameter int T_FLIP       = 130,
  parameter int T_DONE       = 150,
  parameter int T_BURN       = 180,
  parameter int NFLIP        = 2,
  parameter int DWELL        = 3,
  parameter int FLIP_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TEMP_W-1:0]          temp,
  input  logic                       flip,
  input  logic                       clear,
  output logic [1:0]                 status,
  output logic                       need_flip,
  output logic [$clog2(NFLIP+1)-1:0] flips_done,
  output logic [1:0]                 cause
);

  localparam int FW = $clog2(NFLIP + 1);
  localparam logic [TEMP_W-1:0] WARM_TH = TEMP_W'(T_WARM);
  localparam logic [TEMP_W-1:0] FLIP_TH = TEMP_W'(T_FLIP);
  localparam logic [TEMP_W-1:0] DONE_TH = TEMP_W'(T_DONE);
  localparam logic [TEMP_W-1:0] BURN_TH = TEMP_W'(T_BURN);
  localparam logic [FW-1:0]     NFLIP_V = FW'(NFLIP);

  cook_state_t state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic [FW-1:0] flips_q, flips_d, flips_inc;

  logic dwell_inc, dwell_clr, dwell_hit;
  logic to_inc, to_clr, to_hit;
  logic [$clog2(DWELL+1)-1:0]        dwell_cnt;
  logic [$clog2(FLIP_TIMEOUT+1)-1:0] to_cnt;
  logic unused_cnt;

  sat_counter #(.MAX(DWELL)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (dwell_clr),
    .inc   (dwell_inc),
    .cnt   (dwell_cnt),
    .hit   (dwell_hit)
  );

  sat_counter #(.MAX(FLIP_TIMEOUT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (to_clr),
    .inc   (to_inc),
    .cnt   (to_cnt),
    .hit   (to_hit)
  );

  assign unused_cnt = ^{dwell_cnt, to_cnt};

  // Counters only run while their owning state persists; leaving it zeroes them.
  assign dwell_inc = (state_q == S_WARM) && !flip &&
                     (temp >= FLIP_TH) && (temp < DONE_TH);
  assign dwell_clr = clear || (state_d != S_WARM) ||
                     ((state_q == S_WARM) && (temp < FLIP_TH));
  assign to_inc    = (state_q == S_FLIP_WAIT) && !flip;
  assign to_clr    = clear || (state_d != S_FLIP_WAIT);

  assign flips_inc = (flips_q == NFLIP_V) ? flips_q : flips_q + FW'(1);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    flips_d = flips_q;
    if (clear) begin
      state_d = S_RAW;
      cause_d = CAUSE_NONE;
      flips_d = '0;
    end else if ((state_q != S_BURNT) && (temp >= BURN_TH)) begin
      state_d = S_BURNT;
      cause_d = CAUSE_OVERHEAT;
    end else begin
      case (state_q)
        S_RAW: begin
          if (flip) begin
            state_d = S_BURNT;
            cause_d = CAUSE_BADFLIP;
          end else if ((temp >= WARM_TH) && (temp < FLIP_TH)) begin
            state_d = S_WARM;
          end else if (temp >= FLIP_TH) begin
            state_d = S_BURNT;
            cause_d = CAUSE_OVERHEAT;
          end
        end
        S_WARM: begin
          if (flip) begin
            state_d = S_BURNT;
            cause_d = CAUSE_BADFLIP;
          end else if (temp >= DONE_TH) begin
            state_d = S_BURNT;
            cause_d = CAUSE_OVERHEAT;
          end else if (dwell_hit) begin
            state_d = S_FLIP_WAIT;
          end
        end
        S_FLIP_WAIT: begin
          // A flip on the final allowed cycle beats the timeout.
          if (flip) begin
            flips_d = flips_inc;
            state_d = (flips_inc == NFLIP_V) ? S_SEARED : S_WARM;
          end else if (to_hit) begin
            state_d = S_BURNT;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_SEARED: begin
          if (flip) begin
            state_d = S_BURNT;
            cause_d = CAUSE_BADFLIP;
          end else if (temp >= DONE_TH) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (flip) begin
            state_d = S_BURNT;
            cause_d = CAUSE_BADFLIP;
          end
        end
        default: begin
          state_d = S_BURNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RAW;
      cause_q <= CAUSE_NONE;
      flips_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      flips_q <= flips_d;
    end
  end

  always_comb begin
    status = STAT_RAW;
    case (state_q)
      S_WARM, S_FLIP_WAIT, S_SEARED: status = STAT_COOK;
      S_DONE:                        status = STAT_DONE;
      S_BURNT:                       status = STAT_BURNT;
      default:                       status = STAT_RAW;
    endcase
  end

  assign need_flip  = (state_q == S_FLIP_WAIT);
  assign flips_done = flips_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_cook_monitor.sv
// Scoreboard bench for cook_monitor: the driver queues hand-computed outputs
// for every edge, the monitor pops and compares one entry after each edge.
module tb_cook_monitor;

  typedef struct packed {
    logic [1:0] st;
    logic       nf;
    logic [1:0] fd;
    logic [1:0] ca;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] temp;
  logic       flip;
  logic       clear;
  logic [1:0] status;
  logic       need_flip;
  logic [1:0] flips_done;
  logic [1:0] cause;

  exp_t  exp_q[$];
  string name_q[$];
  string scen;
  int    tests  = 0;
  int    failed = 0;
  exp_t  e_m;
  string n_m;

  cook_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .temp       (temp),
    .flip       (flip),
    .clear      (clear),
    .status     (status),
    .need_flip  (need_flip),
    .flips_done (flips_done),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      n_m = name_q.pop_front();
      tests++;
      if ({status, need_flip, flips_done, cause} !== e_m) begin
        failed++;
        $display("FAIL %s: got st=%b nf=%b fd=%0d ca=%b, want st=%b nf=%b fd=%0d ca=%b",
                 n_m, status, need_flip, flips_done, cause, e_m.st, e_m.nf, e_m.fd, e_m.ca);
      end
    end
  end

  task automatic check_now(input string nm, input exp_t e);
    tests++;
    if ({status, need_flip, flips_done, cause} !== e) begin
      failed++;
      $display("FAIL %s: got st=%b nf=%b fd=%0d ca=%b, want st=%b nf=%b fd=%0d ca=%b",
               nm, status, need_flip, flips_done, cause, e.st, e.nf, e.fd, e.ca);
    end
  endtask

  // Drive one sample and queue the outputs expected after the next edge.
  task automatic step(input logic [7:0] t, input logic f, input logic c,
                      input logic [1:0] st, input logic nf,
                      input logic [1:0] fd, input logic [1:0] ca);
    temp  = t;
    flip  = f;
    clear = c;
    exp_q.push_back('{st: st, nf: nf, fd: fd, ca: ca});
    name_q.push_back(scen);
    @(posedge clk);
    @(negedge clk);
  endtask

  // From RAW or WARM: 125 then three in-band samples lands in FLIP_WAIT.
  task automatic to_flip_wait(input logic [1:0] fd);
    step(8'd125, 0, 0, 2'b01, 0, fd, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, fd, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, fd, 2'b00);
    step(8'd140, 0, 0, 2'b01, 1, fd, 2'b00);
  endtask

  task automatic do_clear();
    step(8'd0, 0, 1, 2'b00, 0, 2'd0, 2'b00);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    temp  = 8'd0;
    flip  = 1'b0;
    clear = 1'b0;
    scen  = "reset";
    repeat (2) @(negedge clk);
    check_now("reset_hold", '{st: 2'b00, nf: 0, fd: 2'd0, ca: 2'b00});
    reset = 1'b0;
    step(8'd0, 0, 0, 2'b00, 0, 2'd0, 2'b00);

    scen = "nominal";
    step(8'd125, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd125, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 1, 2'd0, 2'b00);
    step(8'd140, 1, 0, 2'b01, 0, 2'd1, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd1, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd1, 2'b00);
    step(8'd140, 0, 0, 2'b01, 1, 2'd1, 2'b00);
    step(8'd140, 1, 0, 2'b01, 0, 2'd2, 2'b00);
    step(8'd160, 0, 0, 2'b10, 0, 2'd2, 2'b00);
    step(8'd160, 0, 0, 2'b10, 0, 2'd2, 2'b00);
    do_clear();

    scen = "timeout";
    to_flip_wait(2'd0);
    repeat (7) step(8'd140, 0, 0, 2'b01, 1, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b11, 0, 2'd0, 2'b11);
    step(8'd125, 1, 0, 2'b11, 0, 2'd0, 2'b11);
    do_clear();

    scen = "dwell_restart";
    step(8'd125, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd128, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 1, 2'd0, 2'b00);
    do_clear();

    scen = "raw_flip";
    step(8'd100, 1, 0, 2'b11, 0, 2'd0, 2'b10);
    step(8'd125, 0, 0, 2'b11, 0, 2'd0, 2'b10);
    do_clear();

    scen = "raw_too_fast";
    step(8'd135, 0, 0, 2'b11, 0, 2'd0, 2'b01);
    do_clear();

    scen = "seared_overheat";
    to_flip_wait(2'd0);
    step(8'd140, 1, 0, 2'b01, 0, 2'd1, 2'b00);
    to_flip_wait(2'd1);
    step(8'd140, 1, 0, 2'b01, 0, 2'd2, 2'b00);
    step(8'd145, 0, 0, 2'b01, 0, 2'd2, 2'b00);
    step(8'd185, 0, 0, 2'b11, 0, 2'd2, 2'b01);
    step(8'd160, 0, 0, 2'b11, 0, 2'd2, 2'b01);
    do_clear();

    scen = "warm_overheat";
    step(8'd125, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd155, 0, 0, 2'b11, 0, 2'd0, 2'b01);
    step(8'd140, 1, 0, 2'b11, 0, 2'd0, 2'b01);
    do_clear();

    scen = "flip_at_timeout";
    to_flip_wait(2'd0);
    repeat (7) step(8'd140, 0, 0, 2'b01, 1, 2'd0, 2'b00);
    step(8'd140, 1, 0, 2'b01, 0, 2'd1, 2'b00);
    step(8'd125, 0, 0, 2'b01, 0, 2'd1, 2'b00);
    do_clear();

    scen = "burn_with_flip";
    to_flip_wait(2'd0);
    step(8'd190, 1, 0, 2'b11, 0, 2'd0, 2'b01);
    do_clear();

    scen = "clear_with_burn";
    step(8'd125, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd190, 0, 1, 2'b00, 0, 2'd0, 2'b00);
    repeat (3) step(8'd125, 0, 1, 2'b00, 0, 2'd0, 2'b00);
    step(8'd125, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    do_clear();

    scen = "async_reset";
    to_flip_wait(2'd0);
    step(8'd140, 1, 0, 2'b01, 0, 2'd1, 2'b00);
    to_flip_wait(2'd1);
    #1 reset = 1'b1;
    #1 check_now("async_reset_mid", '{st: 2'b00, nf: 0, fd: 2'd0, ca: 2'b00});
    reset = 1'b0;
    step(8'd125, 0, 0, 2'b01, 0, 2'd0, 2'b00);
    step(8'd140, 0, 0, 2'b01, 0, 2'd0, 2'b00);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cook_monitor.md
# cook_monitor

Parametrised cooking-progress monitor: samples a temperature each clock, enforces a warm → dwell → flip (×NFLIP) → done sequence with timing windows, and reports status, flip requests and a fault cause. It is a sticky fault detector driven by a sensor front end and read by the display/alarm logic. It extends the single-flip, fixed-threshold monitor with the following:

- configurable thresholds and width
- multiple required flips
- a minimum dwell before a flip is requested
- a flip timeout
- a synchronous clear
- fault-cause reporting

## Interface

- TEMP_W, 8, temperature width (unsigned)
- T_WARM, 120, lower bound of warm band
- T_FLIP, 130, lower bound of flip band
- T_DONE, 150, lower bound of done band
- T_BURN, 180, overheat threshold
- NFLIP, 2, flips required before done is possible (≥1)
- DWELL, 3, consecutive in-flip-band samples before need_flip (≥1)
- FLIP_TIMEOUT, 8, max cycles need_flip may stay high without a flip (≥1)
- Legal only if T_WARM < T_FLIP < T_DONE < T_BURN < 2^TEMP_W.

Ports:

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- temp  in  TEMP_W  sampled temperature
- flip  in  1  flip event, one sample per cycle high
- clear  in  1  synchronous return to RAW
- status  out  2  00 raw, 01 cooking, 10 done, 11 burnt
- need_flip  out  1  flip requested
- flips_done  out  $clog2(NFLIP+1)  flips accepted so far
- cause  out  2  00 none, 01 overheat, 10 bad flip, 11 flip timeout

## Operation

- States: RAW, WARM, FLIP_WAIT, SEARED, DONE, BURNT.
- Status mapping: RAW→00; WARM, FLIP_WAIT, SEARED→01; DONE→10; BURNT→11.
- need_flip = (state==FLIP_WAIT).
- Priority each edge: reset > clear > overheat > flip/timeout rules > band rules.
- clear: state RAW; all counters, flips_done and cause are zeroed.
- Overheat: temp ≥ T_BURN in any non-BURNT state → BURNT, cause=01.
- RAW:
  - flip → BURNT, cause=10.
  - temp in [T_WARM,T_FLIP) → WARM.
  - temp in [T_FLIP,T_BURN) → BURNT, cause=01 (heated too fast).
  - Otherwise stay in RAW.
- WARM:
  - flip → BURNT, cause=10.
  - temp ≥ T_DONE → BURNT, cause=01.
  - temp in [T_FLIP,T_DONE) increments dwell_cnt; on the DWELL-th consecutive such sample → FLIP_WAIT, dwell_cnt=0.
  - temp < T_FLIP resets dwell_cnt.
- FLIP_WAIT:
  - On flip, flips_done+1. If the new count equals NFLIP → SEARED, otherwise → WARM.
  - The timeout counter clears on every exit from FLIP_WAIT.
  - Without a flip, to_cnt increments; on the FLIP_TIMEOUT-th cycle → BURNT, cause=11.
  - A flip on that same cycle wins over the timeout.
  - Temp falling below T_FLIP does not leave FLIP_WAIT.
- SEARED:
  - flip → BURNT, cause=10.
  - temp in [T_DONE,T_BURN) → DONE.
  - Otherwise stay in SEARED.
- DONE: flip → BURNT, cause=10; otherwise hold.
- BURNT: sticky; only clear or reset leaves it. Inputs are ignored and cause is frozen.
- All comparisons are unsigned and at full TEMP_W width. flips_done saturates at NFLIP.

## Timing

- Reset values: state RAW, status 00, need_flip 0, flips_done 0, cause 00, all counters 0.
- Moore outputs, all registered:
  - The inputs sampled at edge k decide the state after edge k.
  - Outputs reflect that state during cycle k..k+1.
  - There is no combinational path from inputs to outputs.
- With DWELL=1, need_flip rises on the edge that samples the first in-band temp.
- need_flip is high for at most FLIP_TIMEOUT cycles per request.
- Reset mid-sequence aborts immediately, including asynchronously within a cycle.
- clear held for several cycles keeps the block in RAW.

## Structure

- Package cook_pkg holds:
  - the state enum
  - the status codes STAT_RAW/COOK/DONE/BURNT
  - the cause codes CAUSE_NONE/OVERHEAT/BADFLIP/TIMEOUT
- One sub-module, sat_counter (parameter MAX, ports clk/reset/clr/inc, outputs cnt/hit), is instantiated twice: for dwell (MAX=DWELL) and for timeout (MAX=FLIP_TIMEOUT).
- The next-state logic is a single case statement in cook_monitor.

## Test plan

All scenarios use the default parameters.

- Nominal path:
  - Stimulus: temp 125 ×2; 140 ×3; flip; 140 ×3; flip; 160.
  - Required: status 01 from the first sample; need_flip high after the 3rd 140 sample; flips_done 1 then 2; status 10 after the 160 sample; cause 00.
- Flip timeout:
  - Stimulus: reach FLIP_WAIT, then hold temp=140 with no flip for 8 cycles.
  - Required: status 11, cause 11, need_flip 0.
- Dwell restart:
  - Stimulus: temp 125, 140, 140, 128, 140, 140, 140.
  - Required: need_flip rises only after the final 140.
- Fault causes:
  - flip in RAW → cause 10.
  - temp 185 in SEARED → cause 01.
  - temp 155 in WARM → cause 01.
  - Each case: status 11, and it stays 11 with further stimulus.
- Simultaneous events:
  - flip on the 8th FLIP_WAIT cycle → accepted, with no timeout.
  - temp=190 together with flip in FLIP_WAIT → BURNT, cause 01.
  - clear together with temp=190 → RAW.
- Reset and clear mid-sequence:
  - Async reset pulse in FLIP_WAIT: outputs return to reset values before the next edge.
  - clear from BURNT: status 00, cause 00, flips_done 0.
